sal_dfi_dram_model: RTL

DFI-side responder for the SAL DDR controller: plays the PHY+DRAM end of the DFI control, write and read channels. It decodes DDR commands, tracks per-bank open rows, stores write bursts in a small internal array, and returns read bursts with a fixed PHY read latency. It sits opposite the controller's DFI ports in block and system benches and is synthesizable for FPGA prototyping.

---
 rtl/sal_dfi_dram_model.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sal_dfi_dram_model.sv
`default_nettype none
// ============================================================================
// Module   : sal_dfi_dram_model
// Purpose  : DFI-side PHY+DRAM responder: command decode, open-row tracking,
//            burst write storage and fixed-latency read return.
// Options  : SAL_DFI_MODEL_CHECK_EN enables bank-state protocol checks (1-3).
// Revision : 1.0  initial release
// ============================================================================
module sal_dfi_dram_model #(
    parameter int BA_WIDTH    = 2,
    parameter int RA_WIDTH    = 16,
    parameter int CA_WIDTH    = 10,
    parameter int DATA_WIDTH  = 128,
    parameter int BURST_BEATS = 2,
    parameter int MEM_AW      = 10,
    parameter int PHY_RDLAT   = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dfi_cs_n,
    input  logic                    dfi_ras_n,
    input  logic                    dfi_cas_n,
    input  logic                    dfi_we_n,
    input  logic [BA_WIDTH-1:0]     dfi_bank,
    input  logic [RA_WIDTH-1:0]     dfi_address,
    input  logic                    dfi_wrdata_en,
    input  logic [DATA_WIDTH-1:0]   dfi_wrdata,
    input  logic [DATA_WIDTH/8-1:0] dfi_wrdata_mask,
    input  logic                    dfi_rddata_en,
    output logic [DATA_WIDTH-1:0]   dfi_rddata,
    output logic                    dfi_rddata_valid,
    output logic                    err,
    output logic [2:0]              err_code
);
    localparam int BANKS  = 1 << BA_WIDTH;
    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int BB_LOG = $clog2(BURST_BEATS);
    localparam int BBW    = (BB_LOG > 0) ? BB_LOG : 1;
    localparam int BASE_W = MEM_AW - BB_LOG;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BBW-1:0]   LAST_BEAT = BBW'(BURST_BEATS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    logic [2:0] cmd;
    logic       cmd_act;
    logic       cmd_rd;
    logic       cmd_wr;

    assign cmd     = {dfi_ras_n, dfi_cas_n, dfi_we_n};
    assign cmd_act = !dfi_cs_n && (cmd == 3'b011);
    assign cmd_rd  = !dfi_cs_n && (cmd == 3'b101);
    assign cmd_wr  = !dfi_cs_n && (cmd == 3'b100);

    logic [RA_WIDTH-1:0] row_tbl [BANKS];
    logic [BASE_W-1:0]   cmd_base;

    // Burst base index: low bits of {bank, row, column>>3}, using the pre-command row.
    assign cmd_base = BASE_W'({dfi_bank, row_tbl[dfi_bank], dfi_address[CA_WIDTH-1:3]});

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BANKS; i++) row_tbl[i] <= '0;
        end else if (cmd_act) begin
            row_tbl[dfi_bank] <= dfi_address;
        end
    end

    logic [2:0] chk_code;
`ifdef SAL_DFI_MODEL_CHECK_EN
    logic [BANKS-1:0] bank_open;
    logic             cmd_pre;
    logic             cmd_ref;

    assign cmd_pre = !dfi_cs_n && (cmd == 3'b010);
    assign cmd_ref = !dfi_cs_n && (cmd == 3'b001);

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open <= '0;
        end else if (cmd_act) begin
            bank_open[dfi_bank] <= 1'b1;
        end else if (cmd_pre) begin
            if (dfi_address[10]) bank_open <= '0;
            else                 bank_open[dfi_bank] <= 1'b0;
        end
    end

    always_comb begin
        chk_code = 3'd0;
        if (cmd_act && bank_open[dfi_bank])                  chk_code = 3'd1;
        else if ((cmd_rd || cmd_wr) && !bank_open[dfi_bank]) chk_code = 3'd2;
        else if (cmd_ref && (|bank_open))                    chk_code = 3'd3;
    end
`else
    assign chk_code = 3'd0;
`endif

    // Channel 0 = write queue, channel 1 = read queue.
    logic [1:0]          push_req;
    logic [1:0]          data_en;
    logic [1:0]          q_empty;
    logic [1:0]          q_full;
    logic [2*MEM_AW-1:0] beat_idx;

    assign push_req = {cmd_rd, cmd_wr};
    assign data_en  = {dfi_rddata_en, dfi_wrdata_en};

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic [BASE_W-1:0] slots [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [BBW-1:0]    beat;
        logic              do_push;
        logic              do_pop;

        assign q_empty[c] = (count == '0);
        assign q_full[c]  = (count == FULL_CNT);
        assign do_push    = push_req[c] && !q_full[c];
        assign do_pop     = data_en[c] && !q_empty[c] && (beat == LAST_BEAT);
        assign beat_idx[c*MEM_AW +: MEM_AW] = (MEM_AW'(slots[rd_ptr]) << BB_LOG) | MEM_AW'(beat);

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                beat   <= '0;
            end else begin
                if (do_push) begin
                    slots[wr_ptr] <= cmd_base;
                    wr_ptr        <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                end
                if (data_en[c] && !q_empty[c]) begin
                    beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    logic [DATA_WIDTH-1:0] mem [1 << MEM_AW];
    logic                  wr_fire;
    logic                  rd_fire;

    assign wr_fire = dfi_wrdata_en && !q_empty[0];
    assign rd_fire = dfi_rddata_en && !q_empty[1];

    // Storage is deliberately not reset; writes are only blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!dfi_wrdata_mask[b]) mem[beat_idx[MEM_AW-1:0]][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
            end
        end
    end

    logic [PHY_RDLAT-1:0]  vld_pipe;
    logic [DATA_WIDTH-1:0] dat_pipe [PHY_RDLAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < PHY_RDLAT; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= dfi_rddata_en;
            dat_pipe[0] <= rd_fire ? mem[beat_idx[2*MEM_AW-1:MEM_AW]] : '0;
            for (int i = 1; i < PHY_RDLAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign dfi_rddata       = dat_pipe[PHY_RDLAT-1];
    assign dfi_rddata_valid = vld_pipe[PHY_RDLAT-1];

    // Lowest code wins when several errors coincide.
    logic [2:0] new_code;
    always_comb begin
        new_code = chk_code;
        if (new_code == 3'd0 && (|(push_req & q_full)))  new_code = 3'd4;
        if (new_code == 3'd0 && (|(data_en & q_empty))) new_code = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= 3'd0;
        end else if (!err && new_code != 3'd0) begin
            err      <= 1'b1;
            err_code <= new_code;
        end
    end
endmodule
`default_nettype wire
